// File: rtl/gate_stim_checker.sv
// Clocked stimulus sequencer and checker for an `a AND NOT b` gate stage: sweeps all four
// input combinations, samples z after SETTLE cycles, and reports mismatches and a pass flag.
module gate_stim_checker #(
    parameter int unsigned SETTLE = 1  // legal range 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;

    logic [1:0] idx_nxt;
    logic       exp_z;
    logic       mismatch;

    assign idx_nxt  = idx_q + 2'd1;
    assign exp_z    = a_q & ~b_q;
    assign mismatch = (z != exp_z);

    always_comb begin
        // NOTE: every _d gets a hold value first so no path through the case infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    fail_d  = 4'd0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_nxt;
                    a_d     = idx_nxt[1];
                    b_d     = idx_nxt[0];
                    cnt_d   = 4'd0;
                    state_d = WAIT;
                end
            end
            DONE: begin
                // err_q already includes any mismatch on the last combination here
                pass_d  = (err_q == 3'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: doc/gate_stim_checker.md
# gate_stim_checker

Self-checking stimulus sequencer that sits directly upstream of the `a AND NOT b` gate stage. It drives the gate's `a`/`b` inputs through all four input combinations and samples the gate's `z` output after a programmable settle time. It compares each sample against the expected `a & ~b` and reports per-combination mismatches, an error count and a pass flag. It replaces hand-written `initial`-block stimulus with a reusable clocked checker.

## Interface
- `SETTLE`, default 1: cycles `a`/`b` are held stable before `z` is sampled. Legal range 1–15; 0 is illegal.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a sweep. Sampled only in IDLE.
- `a`, output, 1: registered drive to the gate's `a` input.
- `b`, output, 1: registered drive to the gate's `b` input.
- `z`, input, 1: gate output, sampled synchronously.
- `busy`, output, 1: high from the start edge until DONE is entered.
- `done`, output, 1: one-cycle pulse when the sweep completes.
- `pass`, output, 1: 1 when the last sweep had zero mismatches. Held until the next start.
- `err_count`, output, 3: number of mismatches in the last or current sweep (0–4).
- `fail_vec`, output, 4: bit i set if combination i mismatched.

## Operation
- States: IDLE, WAIT, CHECK, DONE. Internal regs: `idx` (2b), `cnt` (4b).
- Combination i: `a = i[1]`, `b = i[0]`. Expected value: `exp = a & ~b`, which is 1 only for i=2.
- IDLE, `start`=1:
  - `idx`←0, `a`←0, `b`←0, `cnt`←0.
  - `fail_vec`←0, `err_count`←0, `pass`←0, `busy`←1.
  - Go to WAIT.
- IDLE, `start`=0: hold all outputs.
- WAIT: if `cnt == SETTLE-1` go to CHECK; otherwise `cnt`←`cnt`+1.
- CHECK: sample `z`.
  - If `z != exp`: `fail_vec[idx]`←1 and `err_count`←`err_count`+1.
  - If `idx==3`: `a`←0, `b`←0, `busy`←0, go to DONE.
  - Otherwise: `idx`←`idx`+1, drive the new `a`/`b`, `cnt`←0, go to WAIT.
- DONE: `done`=1 for exactly this cycle. `pass`←(final `err_count`==0). Next state is IDLE.
- `start` is ignored in WAIT, CHECK and DONE; no queuing.
- `pass` is computed from the fully updated count, including a mismatch on combination 3.
- `err_count` cannot overflow: at most 4 increments per sweep.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0. State is IDLE, `idx`=0, `cnt`=0.
- `reset` has priority over all other inputs. Reset mid-sweep aborts the sweep; no `done` pulse is produced.
- Edge numbering: E0 is the rising edge at which `start` is seen in IDLE.
- Each combination takes SETTLE+1 cycles: SETTLE in WAIT, then 1 in CHECK.
- Combination i is driven from edge E0 + i·(SETTLE+1).
- Combination i is sampled at edge E0 + (i+1)·(SETTLE+1).
- DONE is entered at edge E0 + 4·(SETTLE+1); `done` is high for the following cycle.
- IDLE is re-entered one edge later. The earliest accepted restart is the edge after that.
- For SETTLE=1: samples at E2, E4, E6, E8; `done` high between E8 and E9; `busy` high from E0 to E8.
- `z` may be combinational from `a`/`b`; it must be valid by the sample edge.

## Test plan
- Correct gate (`z = a & ~b`), SETTLE=1, pulse `start` → `fail_vec`=0000, `err_count`=0, `pass`=1, `done` high in the cycle after E8, `busy` falls at E8.
- `z` stuck at 0 → `fail_vec`=0100, `err_count`=1, `pass`=0.
- Plain AND gate (`z = a & b`) → `fail_vec`=1100, `err_count`=2, `pass`=0. Inverted gate (`z = ~(a & ~b)`) → `fail_vec`=1111, `err_count`=4.
- Assert `reset` at E3 of a sweep → all outputs 0 at the next edge, no `done` pulse. A following `start` completes a clean sweep with `pass`=1.
- Hold `start`=1 continuously with the correct gate → restarts are ignored while busy. `done` pulses every 10 cycles with SETTLE=1; `pass` and `err_count` clear at each restart edge.
- SETTLE=3 with the correct gate → `a`/`b` stable for 3 cycles before each CHECK; samples at E4, E8, E12, E16; `done` in the cycle after E16.
